gray_counter: RTL and testbench

Binary-to-Gray direction of the Gray-code block set. This block is a registered up/down counter that holds a binary count and drives the matching Gray code from its own flops, so consecutive Gray outputs differ in exactly one bit. It is the pointer source for clock-domain-crossing FIFOs and rotary/position emulation. Its Gray output is consumed downstream by the gray_to_binary converter.

---
 rtl/gray_counter.sv | 76 +++++++
 tb/tb_gray_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// gray_counter: registered up/down binary counter with a matching registered
// Gray-code output, for CDC FIFO pointers and position emulation.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       synchronous active-high reset (highest priority)
//   en        count enable, one step per cycle while high
//   up        direction when en=1: 1 = increment, 0 = decrement
//   load      synchronous load strobe (overrides en/up)
//   load_bin  binary value to load
//   bin       registered binary count
//   G         registered Gray code of bin
//   wrap      registered one-cycle pulse on modulo roll-over
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] G,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] gray_r;
  logic             wrap_r;

  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;

  // Next-state selection: load > en > hold (reset handled in the register).
  always_comb begin
    w_next_bin  = bin_r;
    w_next_wrap = 1'b0;
    if (load) begin
      w_next_bin = load_bin;
    end else if (en) begin
      if (up) begin
        w_next_bin  = bin_r + WIDTH'(1);
        w_next_wrap = (bin_r == ALL_ONES);
      end else begin
        w_next_bin  = bin_r - WIDTH'(1);
        w_next_wrap = (bin_r == ZERO);
      end
    end
  end

  // Gray is derived from the next binary value so it lands in the same edge.
  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r  <= '0;
      gray_r <= '0;
      wrap_r <= 1'b0;
    end else begin
      bin_r  <= w_next_bin;
      gray_r <= w_next_gray;
      wrap_r <= w_next_wrap;
    end
  end

  assign bin  = bin_r;
  assign G    = gray_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter (WIDTH=4): the driver pushes a
// hand-computed expectation per clock, the monitor pops and compares.
module tb_gray_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] bin;
  logic [W-1:0] G;
  logic         wrap;

  typedef struct packed {
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         w;
    logic         onebit;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  gray_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_bin(load_bin), .bin(bin), .G(G), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and record the expected post-edge outputs.
  task automatic step(input logic r, input logic e, input logic u,
                      input logic l, input logic [W-1:0] lb,
                      input logic [W-1:0] eb, input logic [W-1:0] eg,
                      input logic ew);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; load_bin = lb;
    x.b = eb; x.g = eg; x.w = ew;
    x.onebit = e & ~l & ~r;
    q.push_back(x);
  endtask

  // Monitor: every edge with a pending expectation is compared.
  logic [W-1:0] prev_g = '0;
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      step_no++;
      n_tests++;
      if (bin !== x.b) begin
        n_fail++;
        $display("FAIL step%0d bin: got %h want %h", step_no, bin, x.b);
      end
      n_tests++;
      if (G !== x.g) begin
        n_fail++;
        $display("FAIL step%0d G: got %h want %h", step_no, G, x.g);
      end
      n_tests++;
      if (wrap !== x.w) begin
        n_fail++;
        $display("FAIL step%0d wrap: got %b want %b", step_no, wrap, x.w);
      end
      if (x.onebit) begin
        n_tests++;
        if ($countones(G ^ prev_g) != 1) begin
          n_fail++;
          $display("FAIL step%0d onebit: got %h->%h want single-bit change",
                   step_no, prev_g, G);
        end
      end
      prev_g = G;
    end
  end

  logic [W-1:0] up_bin [16] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
  logic [W-1:0] up_gray[16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    // Reset wins over load and en.
    step(1, 1, 1, 1, 4'h9, 4'h0, 4'h0, 1'b0);
    step(1, 1, 1, 1, 4'h9, 4'h0, 4'h0, 1'b0);
    // Full count-up sweep from 0, wrap only on F->0.
    for (int i = 0; i < 16; i++)
      step(0, 1, 1, 0, 4'h0, up_bin[i], up_gray[i], (i == 15));
    // Count down through zero.
    step(0, 1, 0, 0, 4'h0, 4'hF, 4'h8, 1'b1);
    step(0, 1, 0, 0, 4'h0, 4'hE, 4'h9, 1'b0);
    // Load overrides en; then increment resumes.
    step(0, 1, 1, 1, 4'hA, 4'hA, 4'hF, 1'b0);
    step(0, 1, 1, 0, 4'h0, 4'hB, 4'hE, 1'b0);
    // Hold for 3 cycles at 5, then reverse direction.
    step(0, 0, 0, 1, 4'h5, 4'h5, 4'h7, 1'b0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 0, 4'h0, 4'h5, 4'h7, 1'b0);
    step(0, 1, 1, 0, 4'h0, 4'h6, 4'h5, 1'b0);
    step(0, 1, 0, 0, 4'h0, 4'h5, 4'h7, 1'b0);
    // Reset mid-count, then resume from 0.
    step(0, 0, 0, 1, 4'hC, 4'hC, 4'hA, 1'b0);
    step(1, 1, 1, 1, 4'h3, 4'h0, 4'h0, 1'b0);
    step(0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 1'b0);
    step(0, 1, 1, 0, 4'h0, 4'h2, 4'h3, 1'b0);
    // Load all-ones, wrap up to 0 after a load.
    step(0, 0, 0, 1, 4'hF, 4'hF, 4'h8, 1'b0);
    step(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 1'b1);
    step(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
